count_extender: RTL and testbench

Downstream companion to the 4-bit ripple counter. It samples the ripple counter's `dout_q` on the system clock and accumulates the modulo-16 advance between samples into a wide ACC_W-bit total. It flags each 15→0 wrap and saturation. On request it delivers a stable snapshot of the total through a valid/ready handshake. It turns a free-running 4-bit ripple count into a usable event count for control logic.

---
 rtl/count_extender.sv | 128 ++++++++++++
 tb/tb_count_extender.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/count_extender.sv
// count_extender: widens a free-running 4-bit ripple count into an ACC_W-bit
// saturating event total. Each 15->0 wrap produces a one-cycle pulse. A
// valid/ready handshake delivers a frozen snapshot of the total.
module count_extender #(
  parameter int ACC_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       din_q,
  input  logic             clear,
  input  logic             snap_req,
  input  logic             snap_ready,
  output logic             snap_valid,
  output logic [ACC_W-1:0] snap_count,
  output logic             wrap_pulse,
  output logic             sat
);

  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic {IDLE, HOLD} state_t;

  logic [3:0]       samp_p1;
  logic [3:0]       samp_p2;
  logic             vld_p1;
  logic             vld_p2;
  logic [3:0]       delta_p2;
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   acc_next;
  state_t           state;

  // Adds a 4-bit advance to the total. The top bit of the result flags
  // overflow. On overflow the value is clamped to all-ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [3:0]       d);
    logic [ACC_W:0] sum;
    sum = {1'b0, a} + {{(ACC_W-3){1'b0}}, d};
    if (sum[ACC_W]) begin
      sat_add = {1'b1, ACC_MAX};
    end else begin
      sat_add = sum;
    end
  endfunction

  // Stage p2: modulo-16 advance between the two most recent samples
  assign delta_p2 = samp_p1 - samp_p2;

  // Saturating sum of the current total and the pending advance
  always_comb begin
    acc_next = sat_add(acc, delta_p2);
  end

  // Two-deep sample pipe with valid flags. The flags restart on clear, so the
  // first two samples after reset or clear never form a delta.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      samp_p1 <= 4'd0;
      samp_p2 <= 4'd0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      samp_p1 <= din_q;
      samp_p2 <= samp_p1;
      if (clear) begin
        vld_p1 <= 1'b0;
        vld_p2 <= 1'b0;
      end else begin
        vld_p1 <= 1'b1;
        vld_p2 <= vld_p1;
      end
    end
  end

  // Accumulator, sticky saturation flag and registered wrap pulse. Clear
  // takes priority over accumulation. The wrap pulse still fires while
  // the total is saturated.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      sat        <= 1'b0;
      wrap_pulse <= 1'b0;
    end else if (clear) begin
      acc        <= '0;
      sat        <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= vld_p2 && (samp_p1 < samp_p2);
      if (vld_p2) begin
        acc <= acc_next[ACC_W-1:0];
        if (acc_next[ACC_W]) begin
          sat <= 1'b1;
        end
      end
    end
  end

  // Snapshot handshake. IDLE captures the pre-update total on a request.
  // HOLD keeps the value frozen until the consumer accepts it. Clear
  // never disturbs a pending snapshot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      snap_valid <= 1'b0;
      snap_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_req) begin
            snap_count <= acc;
            snap_valid <= 1'b1;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (snap_ready) begin
            snap_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          snap_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_extender.sv
// Bench for count_extender. A driver issues stimulus and pushes the expected
// per-cycle response and snapshot values into queues. A monitor consumes
// them as the DUT produces outputs.
module tb_count_extender;

  localparam int     ACC_W = 8;
  localparam longint MAX   = (64'd1 << ACC_W) - 1;

  logic             clock;
  logic             reset;
  logic [3:0]       din_q;
  logic             clear;
  logic             snap_req;
  logic             snap_ready;
  logic             snap_valid;
  logic [ACC_W-1:0] snap_count;
  logic             wrap_pulse;
  logic             sat;

  count_extender #(.ACC_W(ACC_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .din_q      (din_q),
    .clear      (clear),
    .snap_req   (snap_req),
    .snap_ready (snap_ready),
    .snap_valid (snap_valid),
    .snap_count (snap_count),
    .wrap_pulse (wrap_pulse),
    .sat        (sat)
  );

  typedef struct {
    logic valid;
    logic wrap;
    logic sat;
  } exp_t;

  int     tests = 0;
  int     fails = 0;
  exp_t   exp_q[$];
  longint snap_q[$];

  // Reference model: samples seen since the last reset/clear, the unbounded
  // true event total, and whether a snapshot is being held.
  int     hist[$];
  longint total;
  bit     holding;
  logic [3:0] cnt;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint acc_model();
    return (total > MAX) ? MAX : total;
  endfunction

  task automatic model_reset();
    hist.delete();
    total   = 0;
    holding = 1'b0;
    snap_q.delete();
  endtask

  // Drive inputs for the coming rising edge and predict its outcome
  task automatic drive(input logic [3:0] d, input logic clr, input logic req,
                       input logic rdy);
    exp_t e;
    int a;
    int b;
    din_q      = d;
    clear      = clr;
    snap_req   = req;
    snap_ready = rdy;
    if (!holding && req) begin
      snap_q.push_back(acc_model());
      holding = 1'b1;
    end else if (holding && rdy) begin
      holding = 1'b0;
    end
    e.valid = holding;
    e.wrap  = 1'b0;
    if (clr) begin
      hist.delete();
      total = 0;
    end else begin
      if (hist.size() >= 2) begin
        a = hist[hist.size()-1];
        b = hist[hist.size()-2];
        total += (a - b + 16) % 16;
        e.wrap = (a < b);
      end
      hist.push_back(int'(d));
      if (hist.size() > 2) void'(hist.pop_front());
    end
    e.sat = (total > MAX);
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [3:0] d, input logic clr, input logic req,
                      input logic rdy);
    @(negedge clock);
    drive(d, clr, req, rdy);
  endtask

  task automatic snap(input logic [3:0] d);
    step(d, 1'b0, 1'b1, 1'b0);
    step(d, 1'b0, 1'b0, 1'b1);
  endtask

  // Reset pulse placed between clock edges. Outputs must drop at once.
  task automatic mid_reset(input string tag);
    @(negedge clock);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk({tag, "_valid"}, snap_valid, 0);
    chk({tag, "_count"}, snap_count, 0);
    chk({tag, "_wrap"},  wrap_pulse, 0);
    chk({tag, "_sat"},   sat,        0);
    #1 reset = 1'b0;
    drive(cnt, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compares each cycle's outputs with the queued expectations.
  // A new snapshot value is popped whenever snap_valid rises.
  initial begin : monitor
    exp_t   e;
    logic   prev_valid;
    longint held;
    prev_valid = 1'b0;
    held       = 0;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("snap_valid", snap_valid, e.valid);
        chk("wrap_pulse", wrap_pulse, e.wrap);
        chk("sat",        sat,        e.sat);
        if (snap_valid && !prev_valid) begin
          if (snap_q.size() == 0) begin
            chk("snap_unexpected", 1, 0);
          end else begin
            held = snap_q.pop_front();
            chk("snap_count", snap_count, held);
          end
        end else if (snap_valid) begin
          chk("snap_stable", snap_count, held);
        end
        prev_valid = snap_valid;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int guard;
    reset      = 1'b1;
    din_q      = 4'd0;
    clear      = 1'b0;
    snap_req   = 1'b0;
    snap_ready = 1'b0;
    cnt        = 4'd0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", snap_valid, 0);
    chk("rst_count", snap_count, 0);
    chk("rst_wrap",  wrap_pulse, 0);
    chk("rst_sat",   sat,        0);
    reset = 1'b0;
    drive(4'd0, 1'b0, 1'b0, 1'b0);

    // Count 0..15,0,1 then snapshot: the total is 17 with a single wrap
    for (int i = 0; i < 18; i++) step(4'(i), 1'b0, 1'b0, 1'b0);
    step(4'd1, 1'b0, 1'b0, 1'b0);
    snap(4'd1);

    // Jump case 3 -> 9 -> 2: advances 6 and 9 give a total of 15
    step(4'd3, 1'b1, 1'b0, 1'b0);
    step(4'd3, 1'b0, 1'b0, 1'b0);
    step(4'd9, 1'b0, 1'b0, 1'b0);
    step(4'd2, 1'b0, 1'b0, 1'b0);
    step(4'd2, 1'b0, 1'b0, 1'b0);
    step(4'd2, 1'b0, 1'b0, 1'b0);
    snap(4'd2);

    // Snapshot of 100 held for 5 counting cycles, with an ignored re-request
    cnt = 4'd2;
    step(cnt, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (acc_model() < 100 && guard < 1000) begin
      cnt++;
      step(cnt, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    step(cnt, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cnt++;
      step(cnt, 1'b0, (k == 2), 1'b0);
    end
    step(cnt, 1'b0, 1'b0, 1'b1);
    step(cnt, 1'b0, 1'b0, 1'b0);

    // Simultaneous clear and request at a total of 42
    step(cnt, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (acc_model() < 42 && guard < 1000) begin
      cnt++;
      step(cnt, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    step(cnt, 1'b1, 1'b1, 1'b0);
    step(cnt, 1'b0, 1'b0, 1'b1);
    repeat (3) step(cnt, 1'b0, 1'b0, 1'b0);
    snap(cnt);

    // Saturation, then clear and a two-edge refill before counting resumes
    for (int i = 0; i < 80; i++) begin
      cnt = cnt + 4'($urandom_range(4, 15));
      step(cnt, 1'b0, 1'b0, 1'b0);
    end
    snap(cnt);
    step(cnt, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cnt++;
      step(cnt, 1'b0, 1'b0, 1'b0);
    end
    snap(cnt);

    // Saturate again, park in HOLD, then reset between edges
    for (int i = 0; i < 80; i++) begin
      cnt = cnt + 4'($urandom_range(4, 15));
      step(cnt, 1'b0, 1'b0, 1'b0);
    end
    step(cnt, 1'b0, 1'b1, 1'b0);
    step(cnt, 1'b0, 1'b0, 1'b0);
    mid_reset("hold_rst");
    for (int i = 0; i < 5; i++) begin
      cnt++;
      step(cnt, 1'b0, 1'b0, 1'b0);
    end
    snap(cnt);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cnt = cnt + 4'($urandom_range(0, 15));
      step(cnt, ($urandom_range(0, 24) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 1));
    end
    repeat (3) step(cnt, 1'b0, 1'b0, 1'b1);
    @(posedge clock);
    #2;
    chk("exp_drained",  exp_q.size(),  0);
    chk("snap_drained", snap_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
